// File: rtl/pio_pkg.sv
// pio_pkg: shared state encoding, count decode and data width for the PIO ISR push path.
package pio_pkg;
  localparam int PIO_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT_IN, WAIT_PUSH} state_t;
  function automatic logic [5:0] dec5(input logic [4:0] v);
    return (v == 5'd0) ? 6'd32 : {1'b0, v};
  endfunction
endpackage

// File: rtl/pio_stall_counter.sv
// pio_stall_counter: 16-bit saturating stall-cycle counter; clr has priority over increment.
module pio_stall_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] count
);
  always_ff @(posedge clk)
    if (!reset_n || clr) count <= '0;
    else if (en && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/pio_isr_push_ctrl.sv
// pio_isr_push_ctrl: IN/PUSH sequencing for the ISR and RX FIFO, with autopush and blocking-push stall.
// Define PIO_PUSH_STALL_CNT_EN to build the stall-cycle counter; otherwise stall_cycles is tied to 0.
module pio_isr_push_ctrl
  import pio_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  penable,
  input  logic                  in_req,
  input  logic [4:0]            in_shift,
  input  logic                  push_req,
  input  logic                  push_iffull,
  input  logic                  push_block,
  input  logic                  autopush,
  input  logic [4:0]            push_thresh,
  input  logic [5:0]            isr_count,
  input  logic [PIO_DATA_W-1:0] isr_data,
  input  logic [PIO_DATA_W-1:0] isr_next,
  input  logic                  rx_full,
  input  logic                  stall_cnt_clr,
  output logic                  isr_do_shift,
  output logic                  isr_clear,
  output logic                  rx_push,
  output logic [PIO_DATA_W-1:0] rx_data,
  output logic                  sm_stall,
  output logic                  rx_drop,
  output logic [15:0]           stall_cycles
);
  state_t state, state_nx;
  logic [5:0] s, t;
  logic [6:0] sum, n;
  logic in_fire, push_fire, release_ok, thresh_hit;

  assign s          = dec5(in_shift);
  assign t          = dec5(push_thresh);
  assign sum        = {1'b0, isr_count} + {1'b0, s};
  assign n          = (sum > 7'd32) ? 7'd32 : sum;
  assign thresh_hit = autopush && (n >= {1'b0, t});
  assign in_fire    = penable && in_req;
  assign push_fire  = penable && push_req && !in_req;
  assign release_ok = penable && !rx_full;

  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx     = state;
    isr_do_shift = 1'b0;
    isr_clear    = 1'b0;
    rx_push      = 1'b0;
    rx_data      = '0;
    sm_stall     = 1'b0;
    rx_drop      = 1'b0;
    case (state)
      IDLE:
        if (in_fire) begin
          if (!thresh_hit) isr_do_shift = 1'b1;
          else if (!rx_full) begin
            rx_push   = 1'b1;
            rx_data   = isr_next;
            isr_clear = 1'b1;
          end else begin
            sm_stall = 1'b1;
            state_nx = WAIT_IN;
          end
        end else if (push_fire && !(push_iffull && isr_count < t)) begin
          isr_clear = !rx_full || !push_block;
          rx_push   = !rx_full;
          rx_data   = rx_full ? '0 : isr_data;
          rx_drop   = rx_full && !push_block;
          sm_stall  = rx_full && push_block;
          state_nx  = (rx_full && push_block) ? WAIT_PUSH : IDLE;
        end
      default: begin
        // Stall holds even with penable low; release pushes in the same cycle.
        sm_stall  = !release_ok;
        rx_push   = release_ok;
        isr_clear = release_ok;
        rx_data   = !release_ok ? '0 : (state == WAIT_IN) ? isr_next : isr_data;
        state_nx  = release_ok ? IDLE : state;
      end
    endcase
  end

`ifdef PIO_PUSH_STALL_CNT_EN
  pio_stall_counter u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (penable && sm_stall),
    .clr     (stall_cnt_clr),
    .count   (stall_cycles)
  );
`else
  logic unused_clr;
  assign unused_clr   = stall_cnt_clr;
  assign stall_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_pio_isr_push_ctrl.sv
// tb_pio_isr_push_ctrl: directed self-checking bench for pio_isr_push_ctrl.
module tb_pio_isr_push_ctrl;
  logic        clk = 1'b0, reset_n, penable, in_req, push_req, push_iffull, push_block, autopush;
  logic        rx_full, stall_cnt_clr;
  logic [4:0]  in_shift, push_thresh;
  logic [5:0]  isr_count;
  logic [31:0] isr_data, isr_next;
  logic        isr_do_shift, isr_clear, rx_push, sm_stall, rx_drop;
  logic [31:0] rx_data;
  logic [15:0] stall_cycles;
  logic [4:0]  o;
  int vectors = 0, miscompares = 0;

  // o = {isr_do_shift, isr_clear, rx_push, sm_stall, rx_drop}
  localparam logic [4:0] NONE = 5'b00000, SHIFT = 5'b10000, PUSH = 5'b01100,
                         STALL = 5'b00010, DROP = 5'b01001;
`ifdef PIO_PUSH_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL3 = 16'd3;
`else
  localparam logic [15:0] EXP_STALL3 = 16'd0;
`endif

  assign o = {isr_do_shift, isr_clear, rx_push, sm_stall, rx_drop};

  pio_isr_push_ctrl dut (
    .clk(clk), .reset_n(reset_n), .penable(penable), .in_req(in_req), .in_shift(in_shift),
    .push_req(push_req), .push_iffull(push_iffull), .push_block(push_block), .autopush(autopush),
    .push_thresh(push_thresh), .isr_count(isr_count), .isr_data(isr_data), .isr_next(isr_next),
    .rx_full(rx_full), .stall_cnt_clr(stall_cnt_clr), .isr_do_shift(isr_do_shift),
    .isr_clear(isr_clear), .rx_push(rx_push), .rx_data(rx_data), .sm_stall(sm_stall),
    .rx_drop(rx_drop), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset_n = 1; penable = 1; in_req = 0; push_req = 0; push_iffull = 0; push_block = 0;
    autopush = 0; rx_full = 0; stall_cnt_clr = 0; in_shift = 0; push_thresh = 0;
    isr_count = 0; isr_data = 0; isr_next = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    step();
    reset_n = 1;
    #1;
    vectors++;
    if (o !== NONE || rx_data !== 32'd0) begin
      $display("FAIL reset_outputs: got %b/%h, want %b/0", o, rx_data, NONE); miscompares++;
    end
    vectors++;
    if (stall_cycles !== 16'd0) begin
      $display("FAIL reset_stall_cycles: got %0d, want 0", stall_cycles); miscompares++;
    end
  endtask

  task automatic test_shift();
    idle_inputs();
    in_req = 1; in_shift = 4; isr_count = 4;
    #1;
    vectors++;
    if (o !== SHIFT) begin $display("FAIL shift_no_autopush: got %b, want %b", o, SHIFT); miscompares++; end
    autopush = 1; push_thresh = 8; isr_count = 2;
    #1;
    vectors++;
    if (o !== SHIFT) begin $display("FAIL shift_below_thresh: got %b, want %b", o, SHIFT); miscompares++; end
    penable = 0;
    #1;
    vectors++;
    if (o !== NONE) begin $display("FAIL penable_low_idle: got %b, want %b", o, NONE); miscompares++; end
    step();
  endtask

  task automatic test_autopush();
    idle_inputs();
    autopush = 1; push_thresh = 8; isr_count = 4; in_req = 1; in_shift = 4; isr_next = 32'hA5;
    #1;
    vectors++;
    if (o !== PUSH || rx_data !== 32'hA5) begin
      $display("FAIL autopush: got %b/%h, want %b/000000a5", o, rx_data, PUSH); miscompares++;
    end
    step();
  endtask

  task automatic test_autopush_full();
    idle_inputs();
    stall_cnt_clr = 1;
    step();
    stall_cnt_clr = 0;
    autopush = 1; push_thresh = 8; isr_count = 4; in_req = 1; in_shift = 4; isr_next = 32'hA5;
    rx_full = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (o !== STALL) begin $display("FAIL autopush_full_stall%0d: got %b, want %b", i, o, STALL); miscompares++; end
      step();
    end
    rx_full = 0;
    #1;
    vectors++;
    if (o !== PUSH || rx_data !== 32'hA5) begin
      $display("FAIL autopush_release: got %b/%h, want %b/000000a5", o, rx_data, PUSH); miscompares++;
    end
    step();
    in_req = 0;
    #1;
    vectors++;
    if (o !== NONE) begin $display("FAIL autopush_back_idle: got %b, want %b", o, NONE); miscompares++; end
    vectors++;
    if (stall_cycles !== EXP_STALL3) begin
      $display("FAIL stall_cycles: got %0d, want %0d", stall_cycles, EXP_STALL3); miscompares++;
    end
  endtask

  task automatic test_block_push();
    idle_inputs();
    push_req = 1; push_block = 1; rx_full = 1; isr_data = 32'h12345678; isr_count = 8;
    #1;
    vectors++;
    if (o !== STALL) begin $display("FAIL block_push_stall: got %b, want %b", o, STALL); miscompares++; end
    step();
    push_req = 0; penable = 0; rx_full = 0;
    #1;
    vectors++;
    if (o !== STALL) begin $display("FAIL penable_low_wait: got %b, want %b", o, STALL); miscompares++; end
    step();
    penable = 1; stall_cnt_clr = 1; rx_full = 1;
    #1;
    vectors++;
    if (o !== STALL) begin $display("FAIL wait_push_hold: got %b, want %b", o, STALL); miscompares++; end
    step();
    stall_cnt_clr = 0;
    vectors++;
    if (stall_cycles !== 16'd0) begin
      $display("FAIL stall_clr_priority: got %0d, want 0", stall_cycles); miscompares++;
    end
    rx_full = 0; in_req = 1;
    #1;
    vectors++;
    if (o !== PUSH || rx_data !== 32'h12345678) begin
      $display("FAIL block_push_release: got %b/%h, want %b/12345678", o, rx_data, PUSH); miscompares++;
    end
    step();
  endtask

  task automatic test_drop();
    idle_inputs();
    push_req = 1; push_block = 0; rx_full = 1; isr_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (o !== DROP || rx_data !== 32'd0) begin
      $display("FAIL nonblock_drop: got %b/%h, want %b/0", o, rx_data, DROP); miscompares++;
    end
    step();
    push_req = 0;
    #1;
    vectors++;
    if (o !== NONE) begin $display("FAIL drop_no_wait: got %b, want %b", o, NONE); miscompares++; end
  endtask

  task automatic test_iffull();
    idle_inputs();
    push_req = 1; push_iffull = 1; push_thresh = 0; isr_count = 31; isr_data = 32'hCAFE;
    #1;
    vectors++;
    if (o !== NONE) begin $display("FAIL iffull_31_of_32: got %b, want %b", o, NONE); miscompares++; end
    isr_count = 32;
    #1;
    vectors++;
    if (o !== PUSH || rx_data !== 32'hCAFE) begin
      $display("FAIL iffull_full_isr: got %b/%h, want %b/0000cafe", o, rx_data, PUSH); miscompares++;
    end
    isr_count = 0; push_thresh = 1;
    #1;
    vectors++;
    if (o !== NONE) begin $display("FAIL iffull_empty_t1: got %b, want %b", o, NONE); miscompares++; end
    step();
  endtask

  task automatic test_boundary();
    idle_inputs();
    autopush = 1; push_thresh = 0; in_req = 1; in_shift = 0; isr_count = 32; isr_next = 32'h77;
    #1;
    vectors++;
    if (o !== PUSH || rx_data !== 32'h77) begin
      $display("FAIL clamp_n32: got %b/%h, want %b/00000077", o, rx_data, PUSH); miscompares++;
    end
    in_shift = 1; isr_count = 30;
    #1;
    vectors++;
    if (o !== SHIFT) begin $display("FAIL t32_n31: got %b, want %b", o, SHIFT); miscompares++; end
    isr_count = 31;
    #1;
    vectors++;
    if (o !== PUSH) begin $display("FAIL t32_n32: got %b, want %b", o, PUSH); miscompares++; end
    step();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    autopush = 1; push_thresh = 8; isr_count = 8; in_req = 1; in_shift = 1; rx_full = 1;
    step();
    in_req = 0;
    #1;
    vectors++;
    if (o !== STALL) begin $display("FAIL mid_wait_stall: got %b, want %b", o, STALL); miscompares++; end
    reset_n = 0;
    step();
    reset_n = 1;
    #1;
    vectors++;
    if (o !== NONE || rx_data !== 32'd0) begin
      $display("FAIL reset_mid_wait: got %b/%h, want %b/0", o, rx_data, NONE); miscompares++;
    end
    vectors++;
    if (stall_cycles !== 16'd0) begin
      $display("FAIL reset_mid_wait_cnt: got %0d, want 0", stall_cycles); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_shift();
    test_autopush();
    test_autopush_full();
    test_block_push();
    test_drop();
    test_iffull();
    test_boundary();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
